// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port block-RAM arbiter.
// Tag values identify the owner of each outstanding read.
package mem_arb_pkg;

    localparam logic TAG_INSTR = 1'b1;
    localparam logic TAG_DATA  = 1'b0;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_INSTR = 2'd1,
        SEL_DATA  = 2'd2
    } sel_e;

endpackage

// File: rtl/mem_arbiter_tag_fifo.sv
// In-order owner FIFO for outstanding slave reads (1-bit tags).
// Push is refused when full, even if a pop happens in the same cycle.
module tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic push_i,
    input  logic tag_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        if (push_ok) begin
            mem_d[wr_q] = tag_i;
            wr_d        = wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one BRAM slave between I-cache refill and data port.
// Define MEMARB_DPRIO_EN for strict data priority instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int ADDRESS = 10,
    parameter  int DEPTH   = 4,
    localparam int BES     = WIDTH / 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               i_read_i,
    output logic               i_rack_o,
    output logic               i_ready_o,
    input  logic [ADDRESS-1:0] i_addr_i,
    output logic [WIDTH-1:0]   i_data_o,
    input  logic               d_read_i,
    input  logic               d_write_i,
    output logic               d_rack_o,
    output logic               d_wack_o,
    output logic               d_ready_o,
    output logic               d_busy_o,
    input  logic [ADDRESS-1:0] d_addr_i,
    input  logic [BES-1:0]     d_bes_ni,
    input  logic [WIDTH-1:0]   d_data_i,
    output logic [WIDTH-1:0]   d_data_o,
    output logic               m_read_o,
    output logic               m_write_o,
    input  logic               m_rack_i,
    input  logic               m_wack_i,
    input  logic               m_ready_i,
    input  logic               m_busy_i,
    output logic [ADDRESS-1:0] m_addr_o,
    output logic [BES-1:0]     m_bes_no,
    output logic [WIDTH-1:0]   m_data_o,
    input  logic [WIDTH-1:0]   m_data_i,
    output logic               err_o
);

    sel_e sel;
    logic full, empty, head;
    logic i_req, d_req;
    logic gnt_i, gnt_d, d_rd;
    logic push, pop, accept;
    logic err_q, err_d;
    logic tie_data;

`ifdef MEMARB_DPRIO_EN
    assign tie_data = 1'b1;
`else
    logic last_q, last_d;

    // Round-robin: the port that did not win last time takes the tie.
    assign tie_data = (last_q == TAG_INSTR);

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = gnt_i ? TAG_INSTR : TAG_DATA;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            last_q <= TAG_DATA;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Reads are blocked when the tag FIFO is full; writes never are.
    assign i_req = i_read_i & ~full;
    assign d_req = d_write_i | (d_read_i & ~full);

    always_comb begin
        sel = SEL_NONE;
        unique case ({i_req, d_req})
            2'b11:   sel = tie_data ? SEL_DATA : SEL_INSTR;
            2'b10:   sel = SEL_INSTR;
            2'b01:   sel = SEL_DATA;
            default: sel = SEL_NONE;
        endcase
    end

    assign gnt_i = (sel == SEL_INSTR);
    assign gnt_d = (sel == SEL_DATA);
    assign d_rd  = gnt_d & ~d_write_i;

    assign m_read_o  = gnt_i | d_rd;
    assign m_write_o = gnt_d & d_write_i;
    assign m_addr_o  = gnt_i ? i_addr_i : d_addr_i;
    assign m_bes_no  = gnt_i ? '0 : d_bes_ni;
    assign m_data_o  = gnt_i ? '0 : d_data_i;

    assign i_rack_o = m_rack_i & gnt_i;
    assign d_rack_o = m_rack_i & d_rd;
    assign d_wack_o = m_wack_i & m_write_o;
    assign d_busy_o = m_busy_i | ((d_read_i | d_write_i) & ~gnt_d);

    assign accept = (m_rack_i & m_read_o) | (m_wack_i & m_write_o);
    assign push   = i_rack_o | d_rack_o;
    assign pop    = m_ready_i & ~empty;

    assign i_ready_o = pop & (head == TAG_INSTR);
    assign d_ready_o = pop & (head == TAG_DATA);
    assign i_data_o  = m_data_i;
    assign d_data_o  = m_data_i;

    tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (push),
        .tag_i   (gnt_i ? TAG_INSTR : TAG_DATA),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign err_d = err_q | (m_ready_i & empty);
    assign err_o = err_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle BRAM slave model.
module tb_mem_arbiter;

    logic        clk;
    logic        reset_i;
    logic        i_read_i, i_rack_o, i_ready_o;
    logic [9:0]  i_addr_i;
    logic [31:0] i_data_o;
    logic        d_read_i, d_write_i, d_rack_o, d_wack_o;
    logic        d_ready_o, d_busy_o;
    logic [9:0]  d_addr_i;
    logic [3:0]  d_bes_ni;
    logic [31:0] d_data_i, d_data_o;
    logic        m_read_o, m_write_o, m_rack_i, m_wack_i;
    logic        m_ready_i, m_busy_i;
    logic [9:0]  m_addr_o;
    logic [3:0]  m_bes_no;
    logic [31:0] m_data_o, m_data_i;
    logic        err_o;

    logic        rel_en, stray;
    logic        rdy_q;
    logic [31:0] dat_q;
    logic [31:0] mem [1024];
    logic [31:0] rq [$];
    logic        c_rd, c_wr, c_pop;
    logic [9:0]  c_addr;
    logic [3:0]  c_bes;
    logic [31:0] c_data;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter #(
        .WIDTH   (32),
        .ADDRESS (10),
        .DEPTH   (4)
    ) dut (
        .clock_i   (clk),
        .reset_i   (reset_i),
        .i_read_i  (i_read_i),
        .i_rack_o  (i_rack_o),
        .i_ready_o (i_ready_o),
        .i_addr_i  (i_addr_i),
        .i_data_o  (i_data_o),
        .d_read_i  (d_read_i),
        .d_write_i (d_write_i),
        .d_rack_o  (d_rack_o),
        .d_wack_o  (d_wack_o),
        .d_ready_o (d_ready_o),
        .d_busy_o  (d_busy_o),
        .d_addr_i  (d_addr_i),
        .d_bes_ni  (d_bes_ni),
        .d_data_i  (d_data_i),
        .d_data_o  (d_data_o),
        .m_read_o  (m_read_o),
        .m_write_o (m_write_o),
        .m_rack_i  (m_rack_i),
        .m_wack_i  (m_wack_i),
        .m_ready_i (m_ready_i),
        .m_busy_i  (m_busy_i),
        .m_addr_o  (m_addr_o),
        .m_bes_no  (m_bes_no),
        .m_data_o  (m_data_o),
        .m_data_i  (m_data_i),
        .err_o     (err_o)
    );

    // Slave: acks at once, returns read data one cycle later in order.
    assign m_rack_i  = m_read_o;
    assign m_wack_i  = m_write_o;
    assign m_busy_i  = 1'b0;
    assign m_ready_i = rdy_q | stray;
    assign m_data_i  = dat_q;

    always @(negedge clk) begin
        c_rd   <= m_read_o & m_rack_i;
        c_wr   <= m_write_o & m_wack_i;
        c_pop  <= rdy_q;
        c_addr <= m_addr_o;
        c_bes  <= m_bes_no;
        c_data <= m_data_o;
    end

    always @(posedge clk) begin
        if (reset_i) begin
            rq.delete();
            rdy_q <= 1'b0;
            dat_q <= 32'h0;
            for (int k = 0; k < 1024; k++) begin
                mem[k] <= 32'h1000_0000 | k;
            end
        end else begin
            if (c_pop) void'(rq.pop_front());
            if (c_rd) rq.push_back(mem[c_addr]);
            if (c_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (!c_bes[b]) mem[c_addr][8*b +: 8] <= c_data[8*b +: 8];
                end
            end
            rdy_q <= rel_en && (rq.size() != 0);
            dat_q <= (rq.size() != 0) ? rq[0] : 32'h0;
        end
    end

    typedef struct {
        logic        ir, dr, dw;
        logic [9:0]  ia, da;
        logic [3:0]  bes;
        logic [31:0] wd;
        logic [7:0]  fl;
        logic [9:0]  ea;
        logic [3:0]  eb;
        logic [31:0] ewd;
        logic [31:0] erd;
    } vec_t;

    function automatic vec_t mk(
        input logic ir, input logic dr, input logic dw,
        input logic [9:0] ia, input logic [9:0] da,
        input logic [3:0] bes, input logic [31:0] wd,
        input logic [7:0] fl, input logic [9:0] ea,
        input logic [3:0] eb, input logic [31:0] ewd,
        input logic [31:0] erd);
        return '{ir, dr, dw, ia, da, bes, wd, fl, ea, eb, ewd, erd};
    endfunction

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic dr, input logic dw,
                         input logic [9:0] ia, input logic [9:0] da,
                         input logic [3:0] bes, input logic [31:0] wd);
        i_read_i  = ir;
        d_read_i  = dr;
        d_write_i = dw;
        i_addr_i  = ia;
        d_addr_i  = da;
        d_bes_ni  = bes;
        d_data_i  = wd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 10'h0, 10'h0, 4'h0, 32'h0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] flags();
        return {m_read_o, m_write_o, i_rack_o, d_rack_o,
                d_wack_o, d_busy_o, i_ready_o, d_ready_o};
    endfunction

    function automatic logic [31:0] rdat();
        return i_ready_o ? i_data_o : (d_ready_o ? d_data_o : 32'h0);
    endfunction

    vec_t vt [15];
    int   n;

    initial begin
        vt[0]  = mk(1, 1, 0, 10'h100, 10'h200, 4'h0, 32'h0,
                    8'b10100100, 10'h100, 4'h0, 32'h0, 32'h0);
        vt[1]  = mk(1, 1, 0, 10'h101, 10'h201, 4'h0, 32'h0,
                    8'b10010010, 10'h201, 4'h0, 32'h0, 32'h1000_0100);
        vt[2]  = mk(1, 1, 0, 10'h102, 10'h202, 4'h0, 32'h0,
                    8'b10100101, 10'h102, 4'h0, 32'h0, 32'h1000_0201);
        vt[3]  = mk(1, 1, 0, 10'h103, 10'h203, 4'h0, 32'h0,
                    8'b10010010, 10'h203, 4'h0, 32'h0, 32'h1000_0102);
        vt[4]  = mk(1, 1, 0, 10'h104, 10'h204, 4'h0, 32'h0,
                    8'b10100101, 10'h104, 4'h0, 32'h0, 32'h1000_0203);
        vt[5]  = mk(1, 1, 0, 10'h105, 10'h205, 4'h0, 32'h0,
                    8'b10010010, 10'h205, 4'h0, 32'h0, 32'h1000_0104);
        vt[6]  = mk(0, 0, 0, 10'h000, 10'h000, 4'h0, 32'h0,
                    8'b00000001, 10'h000, 4'h0, 32'h0, 32'h1000_0205);
        vt[7]  = mk(1, 0, 0, 10'h010, 10'h000, 4'h0, 32'h0,
                    8'b10100000, 10'h010, 4'h0, 32'h0, 32'h0);
        vt[8]  = mk(0, 0, 0, 10'h000, 10'h000, 4'h0, 32'h0,
                    8'b00000010, 10'h000, 4'h0, 32'h0, 32'h1000_0010);
        vt[9]  = mk(0, 0, 1, 10'h000, 10'h020, 4'b0011, 32'hDEAD_BEEF,
                    8'b01001000, 10'h020, 4'b0011, 32'hDEAD_BEEF, 32'h0);
        vt[10] = mk(0, 1, 0, 10'h000, 10'h020, 4'h0, 32'h0,
                    8'b10010000, 10'h020, 4'h0, 32'h0, 32'h0);
        vt[11] = mk(0, 0, 0, 10'h000, 10'h000, 4'h0, 32'h0,
                    8'b00000001, 10'h000, 4'h0, 32'h0, 32'hDEAD_0020);
        vt[12] = mk(0, 1, 1, 10'h000, 10'h030, 4'h0, 32'h1234_5678,
                    8'b01001000, 10'h030, 4'h0, 32'h1234_5678, 32'h0);
        vt[13] = mk(0, 1, 0, 10'h000, 10'h030, 4'h0, 32'h0,
                    8'b10010000, 10'h030, 4'h0, 32'h0, 32'h0);
        vt[14] = mk(0, 0, 0, 10'h000, 10'h000, 4'h0, 32'h0,
                    8'b00000001, 10'h000, 4'h0, 32'h0, 32'h1234_5678);

        reset_i = 1'b1;
        rel_en  = 1'b1;
        stray   = 1'b0;
        idle();
        @(negedge clk);
        check("reset_state",
              {flags(), m_addr_o, m_bes_no, m_data_o, err_o}, '0);
        next();
        reset_i = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].ir, vt[i].dr, vt[i].dw, vt[i].ia, vt[i].da,
                  vt[i].bes, vt[i].wd);
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {flags(), m_addr_o, m_bes_no, m_data_o, rdat()},
                  {vt[i].fl, vt[i].ea, vt[i].eb, vt[i].ewd, vt[i].erd});
            next();
        end

        // Fill the FIFO with held reads, then try a fifth read and a write.
        rel_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 10'h0, 10'h040 + 10'(k), 4'h0, 32'h0);
            @(negedge clk);
            check($sformatf("fill%0d", k), {m_read_o, d_rack_o}, 2'b11);
            next();
        end
        drive(0, 1, 0, 10'h0, 10'h044, 4'h0, 32'h0);
        @(negedge clk);
        check("full_read_held", {m_read_o, d_rack_o, d_busy_o}, 3'b001);
        next();
        drive(1, 0, 1, 10'h045, 10'h050, 4'h0, 32'hCAFE_F00D);
        @(negedge clk);
        check("full_write_ok",
              {m_read_o, m_write_o, i_rack_o, d_wack_o, i_ready_o},
              5'b01010);
        next();
        idle();
        rel_en = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (i_ready_o) check("drain_iready", 1'b1, 1'b0);
            if (d_ready_o && n < 4) begin
                check($sformatf("drain%0d", n), d_data_o,
                      32'h1000_0040 + 32'(n));
                n++;
            end
        end
        check("drain_count", 128'(n), 128'd4);

        next();
        stray = 1'b1;
        @(negedge clk);
        check("stray_no_ready", {i_ready_o, d_ready_o, err_o}, 3'b000);
        next();
        stray = 1'b0;
        @(negedge clk);
        check("stray_err", err_o, 1'b1);

        // Two held reads outstanding (data first), then reset mid-flight.
        next();
        rel_en = 1'b0;
        drive(0, 1, 0, 10'h0, 10'h061, 4'h0, 32'h0);
        @(negedge clk);
        check("mid_drack", d_rack_o, 1'b1);
        next();
        drive(1, 0, 0, 10'h060, 10'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("mid_irack_err", {i_rack_o, err_o}, 2'b11);
        next();
        idle();
        reset_i = 1'b1;
        next();
        reset_i = 1'b0;
        rel_en  = 1'b1;
        @(negedge clk);
        check("mid_after_rst", {err_o, i_ready_o, d_ready_o}, 3'b000);
        next();
        drive(1, 1, 0, 10'h070, 10'h071, 4'h0, 32'h0);
        @(negedge clk);
        check("mid_tie_instr", {i_rack_o, d_rack_o, m_addr_o},
              {1'b1, 1'b0, 10'h070});
        next();
        idle();
        @(negedge clk);
        check("mid_iready", {i_ready_o, d_ready_o, i_data_o},
              {1'b1, 1'b0, 32'h1000_0070});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing one block-RAM slave port between the instruction-cache refill port (read-only) and the TTA data-memory port (read/write, byte enables). Each cycle it grants the slave to one requester and passes that requester's command through. It records the owner of every accepted read in an in-order tag FIFO, so each `m_ready_i` pulse and its `m_data_i` are routed back to the right requester. It sits between `mcache`'s refill port, `tta_hybrid`'s memory port and the `bram4k`/RAMB16 slave.

## Interface
Parameters:
- `WIDTH`, 32, data word width; must be a multiple of 8.
- `ADDRESS`, 10, word-address width.
- `DEPTH`, 4, maximum outstanding reads (tag FIFO depth); power of two, ≥2.
- Derived: `BES` = WIDTH/8; `MSB`/`ASB`/`BSB` = width−1.

Ports:
- `clock_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `i_read_i` in 1: instruction-port read request.
- `i_rack_o` out 1: instruction read accepted.
- `i_ready_o` out 1: instruction read data valid.
- `i_addr_i` in ADDRESS: instruction read address.
- `i_data_o` out WIDTH: instruction read data.
- `d_read_i` in 1: data-port read request.
- `d_write_i` in 1: data-port write request.
- `d_rack_o` out 1: data read accepted.
- `d_wack_o` out 1: data write accepted.
- `d_ready_o` out 1: data read data valid.
- `d_busy_o` out 1: data port not accepting this cycle.
- `d_addr_i` in ADDRESS: data address.
- `d_bes_ni` in BES: data byte enables, active-low.
- `d_data_i` in WIDTH: data write data.
- `d_data_o` out WIDTH: data read data.
- `m_read_o` out 1: slave read request.
- `m_write_o` out 1: slave write request.
- `m_rack_i` in 1: slave read accepted.
- `m_wack_i` in 1: slave write accepted.
- `m_ready_i` in 1: slave read data valid.
- `m_busy_i` in 1: slave busy.
- `m_addr_o` out ADDRESS: slave address.
- `m_bes_no` out BES: slave byte enables, active-low.
- `m_data_o` out WIDTH: slave write data.
- `m_data_i` in WIDTH: slave read data.
- `err_o` out 1: sticky error, set when `m_ready_i` arrives with the tag FIFO empty.

## Operation
- **Grant** is combinational from the requests, the round-robin pointer `last`, and FIFO fullness.
  - Only one port requests: that port is granted.
  - Both request: the port ≠ `last` is granted.
  - `last` updates to the owner on every accepted transfer: `m_rack_i&m_read_o` or `m_wack_i&m_write_o`.
  - `last` resets to "data", so the instruction port wins the first tie.
- **Data-port read and write together:** write takes precedence; the read stays pending.
- **Read blocking:** when the FIFO is full (DEPTH entries), read grants are suppressed for both ports. A data write may still be granted. Push is blocked when full even if a pop occurs in the same cycle.
- **Passthrough:**
  - `m_addr_o`, `m_bes_no`, `m_data_o` are muxed from the granted port.
  - Instruction grants drive `m_bes_no` = all zero and `m_write_o` = 0.
  - No grant: `m_read_o`/`m_write_o` = 0.
- **Acks:** `i_rack_o`, `d_rack_o`, `d_wack_o` = the corresponding slave ack AND the grant to that port/command.
- **`d_busy_o`** = `m_busy_i` OR (data request pending AND not granted).
- **Tag FIFO:**
  - 1-bit tag (1 = instruction); push on accepted read, pop on `m_ready_i`.
  - `i_ready_o` = `m_ready_i` & head==1; `d_ready_o` = `m_ready_i` & head==0.
  - `i_data_o` = `d_data_o` = `m_data_i`.
- **`m_ready_i` with the FIFO empty:** dropped, no ready output, `err_o` set.
- **Reset:**
  - FIFO emptied, `last`=data, `err_o`=0.
  - All outputs go low when inputs are idle; no registered outputs exist other than `err_o`.
  - The slave must be reset in the same cycle; a stray ready after reset sets `err_o`.

## Timing
- Zero-cycle request/ack passthrough: a request in cycle N can be acked in cycle N.
- Read data returns whenever the slave raises `m_ready_i`, typically N+1 for BRAM. Routing is combinational in that cycle.
- Throughput: one accepted transfer per cycle. Back-to-back reads are pipelined up to DEPTH outstanding.
- FIFO push and pop in the same cycle (not full) keep the count unchanged.
- Pointer wrap is modulo DEPTH; count is log2(DEPTH)+1 bits.

## Configuration
- `MEMARB_DPRIO_EN` defined: the data port has strict priority on ties and `last` is unused. Instruction refill can be starved only while the data port requests every cycle.
- Undefined: round-robin as above.

## Structure
- Package `mem_arb_pkg`: tag constants `TAG_INSTR`=1, `TAG_DATA`=0; port-select encoding.
- One sub-module: `tag_fifo` (1-bit, DEPTH entries, push/pop/full/empty/head).

## Test plan
- Instruction only: `i_read_i` at addr 0x010 with 1-cycle BRAM → `i_rack_o` same cycle, `i_ready_o` next cycle, data = mem[0x010].
- Tie: both read every cycle for 6 cycles → grants alternate I,D,I,D,I,D; each ready is routed to the matching port.
- Write: `d_write_i` addr 0x020, data 0xDEADBEEF, `d_bes_ni`=4'b0011 → `m_bes_no`=4'b0011, `d_wack_o`=1. A later read returns 0xDEAD in the upper half.
- FIFO full: DEPTH=4, slave withholds ready → 5th read is held (`m_read_o`=0, `d_busy_o`=1). A concurrent write is still granted.
- Stray ready: `m_ready_i`=1 with FIFO empty → no `*_ready_o`, `err_o`=1 until `reset_i`.
- Mid-flight reset: 2 reads outstanding, `reset_i` for 1 cycle with slave reset → FIFO empty, `err_o`=0, next tie granted to instruction.
